// File: rtl/ex_pipe_slice_pkg.sv
// ex_pipe_slice_pkg: shared widths, pipeline indices, funct3 codes and stage record types
// Revision: 1.0
`default_nettype none
package ex_pipe_slice_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int REG_AWIDTH = 5;
  localparam int STG_N      = 5;

  typedef logic [DATA_WIDTH-1:0] DataBus;
  typedef logic [REG_AWIDTH-1:0] RegAddrBus;
  typedef logic [STG_N-1:0]      StallBus;
  typedef logic [STG_N-1:0]      FlushBus;

  localparam int IDX_PC    = 0;
  localparam int IDX_IFID  = 1;
  localparam int IDX_IDEX  = 2;
  localparam int IDX_EXMEM = 3;
  localparam int IDX_MEMWB = 4;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // An all-zero record is a NOP bubble for either register.
  typedef struct packed {
    DataBus    pc;
    DataBus    d1;
    DataBus    d2;
    DataBus    imm;
    RegAddrBus r1;
    RegAddrBus r2;
    RegAddrBus rd;
    logic [2:0] f3;
    logic      f7_5;
    logic      imm_sel;
    logic      pc_sel;
    logic      jmp;
    logic      br;
    logic      lui;
    logic      mem_re;
    logic      mem_wr;
    logic [2:0] mem_f3;
    logic      wb_reg_wr;
    logic      wb_mem_sel;
  } idex_t;

  typedef struct packed {
    RegAddrBus rd;
    DataBus    alu;
    DataBus    wdata;
    logic      mem_re;
    logic      mem_wr;
    logic [2:0] mem_f3;
    logic      wb_reg_wr;
    logic      wb_mem_sel;
  } exmem_t;
endpackage
`default_nettype wire

// File: rtl/ex_pipe_slice_alu.sv
// ex_alu: combinational RV32I ALU, redirect adder and branch comparator
// Revision: 1.0
`default_nettype none
module ex_alu
  import ex_pipe_slice_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  input  logic [2:0]            f3,
  input  logic                  f7_5,
  input  logic                  imm_sel,
  input  logic                  force_add,
  output logic [DATA_WIDTH-1:0] sum,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  cond
);
  logic [4:0] shamt;

  assign shamt = b[4:0];
  assign sum   = a + b;

  always_comb begin
    res = sum;
    if (!force_add) begin
      case (f3)
        F3_ADD:  res = (f7_5 && !imm_sel) ? a - b : sum;
        F3_SLL:  res = a << shamt;
        F3_SLT:  res = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
        F3_SLTU: res = {{(DATA_WIDTH-1){1'b0}}, a < b};
        F3_XOR:  res = a ^ b;
        F3_SR:   res = f7_5 ? DataBus'($signed(a) >>> shamt) : a >> shamt;
        F3_OR:   res = a | b;
        F3_AND:  res = a & b;
        default: res = sum;
      endcase
    end
  end

  always_comb begin
    cond = 1'b0;
    case (f3)
      BR_EQ:   cond = (rs1 == rs2);
      BR_NE:   cond = (rs1 != rs2);
      BR_LT:   cond = ($signed(rs1) <  $signed(rs2));
      BR_GE:   cond = ($signed(rs1) >= $signed(rs2));
      BR_LTU:  cond = (rs1 <  rs2);
      BR_GEU:  cond = (rs1 >= rs2);
      default: cond = 1'b0;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/ex_pipe_slice.sv
// ex_pipe_slice: ID/EX register, forwarding + execute, EX/MEM register
// Revision: 1.0
`default_nettype none
module ex_pipe_slice
  import ex_pipe_slice_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        stall_i,
  input  logic [4:0]        flush_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] d1_i,
  input  logic [DATA_W-1:0] d2_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] r1_i,
  input  logic [REG_AW-1:0] r2_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [2:0]        ex_f3_i,
  input  logic [6:0]        ex_f7_i,
  input  logic              ex_imm_sel_i,
  input  logic              ex_pc_sel_i,
  input  logic              ex_jmp_i,
  input  logic              ex_br_i,
  input  logic              ex_lui_i,
  input  logic              mem_re_i,
  input  logic              mem_wr_i,
  input  logic [2:0]        mem_f3_i,
  input  logic              wb_reg_wr_i,
  input  logic              wb_mem_sel_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_wdata_i,
  input  logic              memwb_wb_reg_wr_i,
  output logic [DATA_W-1:0] br_addr,
  output logic              br_jmp_en,
  output logic [REG_AW-1:0] exmem_rd,
  output logic [DATA_W-1:0] exmem_alu,
  output logic [DATA_W-1:0] exmem_wdata,
  output logic              exmem_mem_re,
  output logic              exmem_mem_wr,
  output logic [2:0]        exmem_mem_f3,
  output logic              exmem_wb_reg_wr,
  output logic              exmem_wb_mem_sel
);
  idex_t  idex, idex_nxt;
  exmem_t exmem, exmem_nxt;
  DataBus fwd1, fwd2, op_a, op_b, sum, res;
  logic   cond;
  logic   unused_bits;

  always_comb begin
    idex_nxt            = '0;
    idex_nxt.pc         = pc_i;
    idex_nxt.d1         = d1_i;
    idex_nxt.d2         = d2_i;
    idex_nxt.imm        = imm_i;
    idex_nxt.r1         = r1_i;
    idex_nxt.r2         = r2_i;
    idex_nxt.rd         = rd_i;
    idex_nxt.f3         = ex_f3_i;
    idex_nxt.f7_5       = ex_f7_i[5];
    idex_nxt.imm_sel    = ex_imm_sel_i;
    idex_nxt.pc_sel     = ex_pc_sel_i;
    idex_nxt.jmp        = ex_jmp_i;
    idex_nxt.br         = ex_br_i;
    idex_nxt.lui        = ex_lui_i;
    idex_nxt.mem_re     = mem_re_i;
    idex_nxt.mem_wr     = mem_wr_i;
    idex_nxt.mem_f3     = mem_f3_i;
    idex_nxt.wb_reg_wr  = wb_reg_wr_i;
    idex_nxt.wb_mem_sel = wb_mem_sel_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         idex <= '0;
    else if (flush_i[IDX_IDEX])      idex <= '0;
    else if (!stall_i[IDX_IDEX])     idex <= idex_nxt;
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  always_comb begin
    fwd1 = idex.d1;
    if (exmem.wb_reg_wr && exmem.rd == idex.r1 && exmem.rd != '0)
      fwd1 = exmem.alu;
    else if (memwb_wb_reg_wr_i && memwb_rd_i == idex.r1 && memwb_rd_i != '0)
      fwd1 = memwb_wdata_i;
    fwd2 = idex.d2;
    if (exmem.wb_reg_wr && exmem.rd == idex.r2 && exmem.rd != '0)
      fwd2 = exmem.alu;
    else if (memwb_wb_reg_wr_i && memwb_rd_i == idex.r2 && memwb_rd_i != '0)
      fwd2 = memwb_wdata_i;
  end

  assign op_a = idex.lui ? '0 : (idex.pc_sel ? idex.pc : fwd1);
  assign op_b = idex.imm_sel ? idex.imm : fwd2;

  ex_alu u_alu (
    .a         (op_a),
    .b         (op_b),
    .rs1       (fwd1),
    .rs2       (fwd2),
    .f3        (idex.f3),
    .f7_5      (idex.f7_5),
    .imm_sel   (idex.imm_sel),
    .force_add (idex.br | idex.jmp),
    .sum       (sum),
    .res       (res),
    .cond      (cond)
  );

  // JALR drops bit 0 of its target; PC-relative targets pass through.
  assign br_addr   = {sum[DATA_WIDTH-1:1], sum[0] & ~(idex.jmp & ~idex.pc_sel)};
  assign br_jmp_en = idex.jmp | (idex.br & cond);

  always_comb begin
    exmem_nxt            = '0;
    exmem_nxt.rd         = idex.rd;
    exmem_nxt.alu        = idex.jmp ? idex.pc + 32'd4 : res;
    exmem_nxt.wdata      = fwd2;
    exmem_nxt.mem_re     = idex.mem_re;
    exmem_nxt.mem_wr     = idex.mem_wr;
    exmem_nxt.mem_f3     = idex.mem_f3;
    exmem_nxt.wb_reg_wr  = idex.wb_reg_wr;
    exmem_nxt.wb_mem_sel = idex.wb_mem_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         exmem <= '0;
    else if (flush_i[IDX_EXMEM])     exmem <= '0;
    else if (!stall_i[IDX_EXMEM])    exmem <= exmem_nxt;
  end

  assign exmem_rd         = exmem.rd;
  assign exmem_alu        = exmem.alu;
  assign exmem_wdata      = exmem.wdata;
  assign exmem_mem_re     = exmem.mem_re;
  assign exmem_mem_wr     = exmem.mem_wr;
  assign exmem_mem_f3     = exmem.mem_f3;
  assign exmem_wb_reg_wr  = exmem.wb_reg_wr;
  assign exmem_wb_mem_sel = exmem.wb_mem_sel;

  // Other pipeline stages' control bits and unused funct7 bits belong elsewhere.
  assign unused_bits = &{1'b0, stall_i[IDX_PC], stall_i[IDX_IFID], stall_i[IDX_MEMWB],
                         flush_i[IDX_PC], flush_i[IDX_IFID], flush_i[IDX_MEMWB],
                         ex_f7_i[6], ex_f7_i[4:0]};
endmodule
`default_nettype wire

// File: tb/tb_ex_pipe_slice.sv
// tb_ex_pipe_slice: directed vectors with hand-computed results for ex_pipe_slice
// Revision: 1.0
`default_nettype none
module tb_ex_pipe_slice;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  stall_i, flush_i;
  logic [31:0] pc_i, d1_i, d2_i, imm_i;
  logic [4:0]  r1_i, r2_i, rd_i;
  logic [2:0]  ex_f3_i, mem_f3_i;
  logic [6:0]  ex_f7_i;
  logic        ex_imm_sel_i, ex_pc_sel_i, ex_jmp_i, ex_br_i, ex_lui_i;
  logic        mem_re_i, mem_wr_i, wb_reg_wr_i, wb_mem_sel_i;
  logic [4:0]  memwb_rd_i;
  logic [31:0] memwb_wdata_i;
  logic        memwb_wb_reg_wr_i;
  logic [31:0] br_addr, exmem_alu, exmem_wdata;
  logic        br_jmp_en, exmem_mem_re, exmem_mem_wr, exmem_wb_reg_wr, exmem_wb_mem_sel;
  logic [4:0]  exmem_rd;
  logic [2:0]  exmem_mem_f3;

  int n_cmp = 0;
  int n_err = 0;

  ex_pipe_slice dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .pc_i(pc_i), .d1_i(d1_i), .d2_i(d2_i), .imm_i(imm_i),
    .r1_i(r1_i), .r2_i(r2_i), .rd_i(rd_i),
    .ex_f3_i(ex_f3_i), .ex_f7_i(ex_f7_i), .ex_imm_sel_i(ex_imm_sel_i),
    .ex_pc_sel_i(ex_pc_sel_i), .ex_jmp_i(ex_jmp_i), .ex_br_i(ex_br_i), .ex_lui_i(ex_lui_i),
    .mem_re_i(mem_re_i), .mem_wr_i(mem_wr_i), .mem_f3_i(mem_f3_i),
    .wb_reg_wr_i(wb_reg_wr_i), .wb_mem_sel_i(wb_mem_sel_i),
    .memwb_rd_i(memwb_rd_i), .memwb_wdata_i(memwb_wdata_i),
    .memwb_wb_reg_wr_i(memwb_wb_reg_wr_i),
    .br_addr(br_addr), .br_jmp_en(br_jmp_en),
    .exmem_rd(exmem_rd), .exmem_alu(exmem_alu), .exmem_wdata(exmem_wdata),
    .exmem_mem_re(exmem_mem_re), .exmem_mem_wr(exmem_mem_wr), .exmem_mem_f3(exmem_mem_f3),
    .exmem_wb_reg_wr(exmem_wb_reg_wr), .exmem_wb_mem_sel(exmem_wb_mem_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    pc_i = '0; d1_i = '0; d2_i = '0; imm_i = '0;
    r1_i = '0; r2_i = '0; rd_i = '0;
    ex_f3_i = '0; ex_f7_i = '0; ex_imm_sel_i = 0; ex_pc_sel_i = 0;
    ex_jmp_i = 0; ex_br_i = 0; ex_lui_i = 0;
    mem_re_i = 0; mem_wr_i = 0; mem_f3_i = '0; wb_reg_wr_i = 0; wb_mem_sel_i = 0;
  endtask

  task automatic present(input logic [31:0] pc, d1, d2, imm, input logic [4:0] r1, r2, rd,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic isel, psel, jmp, br, lui, wb);
    bubble();
    pc_i = pc; d1_i = d1; d2_i = d2; imm_i = imm;
    r1_i = r1; r2_i = r2; rd_i = rd; ex_f3_i = f3; ex_f7_i = f7;
    ex_imm_sel_i = isel; ex_pc_sel_i = psel; ex_jmp_i = jmp; ex_br_i = br;
    ex_lui_i = lui; wb_reg_wr_i = wb;
  endtask

  // Instruction into ID/EX, then a bubble behind it so it lands alone in EX/MEM.
  task automatic run();
    step();
    bubble();
    step();
  endtask

  initial begin
    rst = 1'b1; stall_i = '0; flush_i = '0;
    memwb_rd_i = '0; memwb_wdata_i = '0; memwb_wb_reg_wr_i = 0;
    bubble();
    step();
    check("rst_alu", exmem_alu, 32'h0);
    check("rst_rd", {27'b0, exmem_rd}, 32'h0);
    check("rst_wb", {31'b0, exmem_wb_reg_wr}, 32'h0);
    check("rst_br_en", {31'b0, br_jmp_en}, 32'h0);
    rst = 1'b0;

    // ADDI x1,x0,5 ; ADD x2,x1,x1 ; ADD x5,x2,x2 (EX/MEM beats MEM/WB)
    present(0, 0, 0, 5, 0, 0, 1, 3'b000, 7'h00, 1, 0, 0, 0, 0, 1);
    step();
    present(4, 0, 0, 0, 1, 1, 2, 3'b000, 7'h00, 0, 0, 0, 0, 0, 1);
    step();
    check("addi_alu", exmem_alu, 32'd5);
    check("addi_rd", {27'b0, exmem_rd}, 32'd1);
    present(8, 0, 0, 0, 2, 2, 5, 3'b000, 7'h00, 0, 0, 0, 0, 0, 1);
    memwb_rd_i = 5'd2; memwb_wdata_i = 32'h99; memwb_wb_reg_wr_i = 1;
    step();
    check("fwd_exmem", exmem_alu, 32'd10);
    check("fwd_exmem_rd", {27'b0, exmem_rd}, 32'd2);
    bubble();
    step();
    check("fwd_priority", exmem_alu, 32'd20);

    // MEM/WB forwarding, and never from x0
    present(0, 0, 0, 0, 3, 0, 6, 3'b000, 7'h00, 0, 0, 0, 0, 0, 1);
    memwb_rd_i = 5'd3; memwb_wdata_i = 32'h55; memwb_wb_reg_wr_i = 1;
    run();
    check("fwd_memwb", exmem_alu, 32'h55);
    present(0, 32'h11, 0, 0, 0, 0, 7, 3'b000, 7'h00, 0, 0, 0, 0, 0, 1);
    memwb_rd_i = 5'd0; memwb_wdata_i = 32'h77;
    run();
    check("fwd_x0", exmem_alu, 32'h11);
    memwb_wb_reg_wr_i = 0;

    present(0, 3, 5, 0, 8, 9, 10, 3'b000, 7'h20, 0, 0, 0, 0, 0, 1);
    run();
    check("sub", exmem_alu, 32'hFFFF_FFFE);
    present(0, 32'h8000_0000, 4, 0, 8, 9, 10, 3'b101, 7'h20, 0, 0, 0, 0, 0, 1);
    run();
    check("sra", exmem_alu, 32'hF800_0000);
    present(0, 32'h8000_0000, 4, 0, 8, 9, 10, 3'b101, 7'h00, 0, 0, 0, 0, 0, 1);
    run();
    check("srl", exmem_alu, 32'h0800_0000);
    present(0, 1, 32'hFFFF_FFFF, 0, 8, 9, 10, 3'b011, 7'h00, 0, 0, 0, 0, 0, 1);
    run();
    check("sltu", exmem_alu, 32'd1);
    present(0, 1, 32'hFFFF_FFFF, 0, 8, 9, 10, 3'b010, 7'h00, 0, 0, 0, 0, 0, 1);
    run();
    check("slt", exmem_alu, 32'd0);
    present(0, 32'h100, 0, 32'hFFFF_FFE0, 8, 0, 10, 3'b000, 7'h7F, 1, 0, 0, 0, 0, 1);
    run();
    check("addi_neg", exmem_alu, 32'hE0);
    present(32'h500, 32'h1234, 0, 32'hABCD_E000, 8, 0, 10, 3'b000, 7'h55, 1, 0, 0, 0, 1, 1);
    run();
    check("lui", exmem_alu, 32'hABCD_E000);

    // Store: address rs1+imm, data = rs2, memory controls pass through
    present(0, 32'h1000, 32'hCAFE, 8, 8, 9, 0, 3'b000, 7'h00, 1, 0, 0, 0, 0, 0);
    mem_wr_i = 1; mem_f3_i = 3'b010;
    run();
    check("st_addr", exmem_alu, 32'h1008);
    check("st_data", exmem_wdata, 32'hCAFE);
    check("st_wr", {31'b0, exmem_mem_wr}, 32'd1);
    check("st_f3", {29'b0, exmem_mem_f3}, 32'd2);

    // Branches
    present(32'h100, 7, 7, 32'h20, 8, 9, 0, 3'b000, 7'h00, 1, 1, 0, 1, 0, 0);
    step();
    check("beq_en", {31'b0, br_jmp_en}, 32'd1);
    check("beq_addr", br_addr, 32'h120);
    bubble(); step();
    present(32'h100, 7, 8, 32'h20, 8, 9, 0, 3'b000, 7'h00, 1, 1, 0, 1, 0, 0);
    step();
    check("beq_nt", {31'b0, br_jmp_en}, 32'd0);
    bubble(); step();
    present(32'h100, 32'hFFFF_FFFF, 1, 32'h20, 8, 9, 0, 3'b100, 7'h00, 1, 1, 0, 1, 0, 0);
    step();
    check("blt_en", {31'b0, br_jmp_en}, 32'd1);
    bubble(); step();
    present(32'h100, 32'hFFFF_FFFF, 1, 32'h20, 8, 9, 0, 3'b110, 7'h00, 1, 1, 0, 1, 0, 0);
    step();
    check("bltu_nt", {31'b0, br_jmp_en}, 32'd0);
    bubble(); step();
    present(32'h100, 32'hFFFF_FFFF, 1, 32'h20, 8, 9, 0, 3'b111, 7'h00, 1, 1, 0, 1, 0, 0);
    step();
    check("bgeu_en", {31'b0, br_jmp_en}, 32'd1);
    bubble(); step();

    // JALR, then a flush of ID/EX behind it
    present(32'h40, 32'h81, 0, 0, 8, 0, 1, 3'b000, 7'h00, 1, 0, 1, 0, 0, 1);
    step();
    check("jalr_en", {31'b0, br_jmp_en}, 32'd1);
    check("jalr_addr", br_addr, 32'h80);
    flush_i = 5'b00100;
    step();
    check("jalr_link", exmem_alu, 32'h44);
    check("jalr_wb", {31'b0, exmem_wb_reg_wr}, 32'd1);
    check("flush_no_redirect", {31'b0, br_jmp_en}, 32'd0);
    flush_i = '0;
    bubble();
    step();
    check("flush_bubble_wb", {31'b0, exmem_wb_reg_wr}, 32'd0);

    // Stall of ID/EX and EX/MEM for two cycles
    present(0, 0, 0, 9, 0, 0, 3, 3'b000, 7'h00, 1, 0, 0, 0, 0, 1);
    step();
    present(0, 0, 0, 1, 0, 0, 4, 3'b000, 7'h00, 1, 0, 0, 0, 0, 1);
    step();
    present(0, 0, 0, 32'h33, 0, 0, 5, 3'b000, 7'h00, 1, 0, 0, 0, 0, 1);
    stall_i = 5'b01100;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_alu", exmem_alu, 32'd9);
      check("stall_rd", {27'b0, exmem_rd}, 32'd3);
    end
    stall_i = '0;
    bubble();
    step();
    check("stall_release", exmem_alu, 32'd1);
    check("stall_release_rd", {27'b0, exmem_rd}, 32'd4);

    // Flush beats stall on ID/EX
    present(0, 0, 0, 32'h44, 0, 0, 6, 3'b000, 7'h00, 1, 0, 0, 0, 0, 1);
    stall_i = 5'b00100; flush_i = 5'b00100;
    step();
    stall_i = '0; flush_i = '0;
    bubble();
    step();
    check("stflush_wb", {31'b0, exmem_wb_reg_wr}, 32'd0);
    check("stflush_alu", exmem_alu, 32'd0);

    // Asynchronous reset mid-cycle
    present(0, 0, 0, 32'h5A, 0, 0, 7, 3'b000, 7'h00, 1, 0, 0, 0, 0, 1);
    step();
    present(32'h200, 0, 0, 8, 0, 0, 1, 3'b000, 7'h00, 1, 1, 1, 0, 0, 1);
    step();
    check("pre_rst_alu", exmem_alu, 32'h5A);
    check("jal_en", {31'b0, br_jmp_en}, 32'd1);
    check("jal_addr", br_addr, 32'h208);
    #2 rst = 1'b1;
    #1;
    check("arst_alu", exmem_alu, 32'd0);
    check("arst_rd", {27'b0, exmem_rd}, 32'd0);
    check("arst_wb", {31'b0, exmem_wb_reg_wr}, 32'd0);
    check("arst_br_en", {31'b0, br_jmp_en}, 32'd0);
    bubble();
    #1 rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/ex_pipe_slice.md
Name: ex_pipe_slice

Overview:
RV32I execute slice: ID/EX pipeline register, combinational execute logic (operand forwarding, ALU, branch/jump resolution) and EX/MEM pipeline register. It sits between the decode stage and data memory. Branch/jump redirect goes to the PC register and flush network. MEM/WB forwarding data comes back from the writeback stage.

Parameters:
DATA_W, 32, datapath and PC width
REG_AW, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall_i  in  5  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB; 1 holds that register
flush_i  in  5  same indices; 1 loads a bubble
pc_i, d1_i, d2_i, imm_i  in  32 each  decode PC, rs1/rs2 read data, sign-extended immediate
r1_i, r2_i, rd_i  in  5 each  source and destination register addresses
ex_f3_i  in  3  funct3
ex_f7_i  in  7  funct7 (instr[31:25])
ex_imm_sel_i  in  1  operand B = imm (else rs2)
ex_pc_sel_i  in  1  operand A = PC (else rs1)
ex_jmp_i, ex_br_i, ex_lui_i  in  1 each  JAL/JALR, conditional branch, LUI (operand A = 0)
mem_re_i, mem_wr_i  in  1 each  load, store
mem_f3_i  in  3  memory access size/sign
wb_reg_wr_i  in  1  writes rd
wb_mem_sel_i  in  1  writeback source is memory
memwb_rd_i  in  5  MEM/WB destination
memwb_wdata_i  in  32  MEM/WB writeback data
memwb_wb_reg_wr_i  in  1  MEM/WB write enable
br_addr  out  32  redirect target (combinational)
br_jmp_en  out  1  redirect taken (combinational)
exmem_rd  out  5  registered EX/MEM field
exmem_alu  out  32  registered EX/MEM field
exmem_wdata  out  32  registered EX/MEM field
exmem_mem_re, exmem_mem_wr  out  1 each  registered EX/MEM fields
exmem_mem_f3  out  3  registered EX/MEM field
exmem_wb_reg_wr, exmem_wb_mem_sel  out  1 each  registered EX/MEM fields

Behaviour:
- Reset: every ID/EX and EX/MEM field is 0 (a NOP bubble). All exmem_* outputs are 0. br_jmp_en is 0.
- ID/EX per clock edge, in priority order: flush_i[2] clears all fields; else stall_i[2] holds; else loads the *_i inputs.
- EX/MEM uses the same rule with index 3. Its inputs are the ID/EX control fields and rd plus the execute results.
- Forwarding for rs1 and for rs2 independently:
  - If EX/MEM wb_reg_wr=1, rd==rs and rd!=0, take exmem_alu.
  - Else if memwb_wb_reg_wr_i=1, memwb_rd_i==rs and memwb_rd_i!=0, take memwb_wdata_i.
  - Else take the ID/EX data. EX/MEM has priority.
- Load-use hazards are not detected in this block. Stalling for them is external.
- Operand A = 0 if lui; else PC if pc_sel; else forwarded rs1. Operand B = imm if imm_sel, else forwarded rs2.
- ALU when br=0 and jmp=0, selected by f3:
  - 000: SUB if f7[5]=1 and imm_sel=0, else ADD.
  - 001 SLL, 010 SLT (signed), 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 101: SRA if f7[5]=1, else SRL.
  - Shift amount is B[4:0].
- When br=1 or jmp=1 the adder forces ADD: target = A+B. For JALR (jmp=1, pc_sel=0) target bit0 is cleared. br_addr = target.
- Branch condition on forwarded rs1/rs2 by f3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010/011 never taken.
- br_jmp_en = jmp | (br & cond), all gated by a valid ID/EX entry. A flushed entry has all controls 0, so it never redirects.
- EX/MEM alu field = PC+4 when jmp=1, else the ALU result. wdata = forwarded rs2 (store data).
- Loads and stores arrive with ex_f3=000, so the address is rs1+imm.
- Arithmetic is 32-bit modulo (wrap-around). No exceptions. Misaligned targets pass through unchanged.
- Stall and flush on the same register in the same cycle: flush wins.

Decomposition:
- Shared package holds: bus widths (DataBus, RegAddrBus, StallBus, FlushBus), stall/flush bit indices, ALU f3 codes, branch f3 codes.
- One natural sub-module, ex_alu: combinational ALU plus branch comparator. Forwarding muxes and both pipeline registers stay in the top.

Test Plan:
- ADDI x1,x0,5 then ADD x2,x1,x1 back-to-back -> EX/MEM forward; exmem_alu=10 for the second instruction.
- SUB with rs1=3, rs2=5 -> exmem_alu=0xFFFFFFFE; SRA 0x80000000 by 4 -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1.
- BEQ pc=0x100, imm=0x20, rs1=rs2=7 -> br_jmp_en=1, br_addr=0x120; with rs2=8 -> br_jmp_en=0.
- JALR pc=0x40, rs1=0x81, imm=0 -> br_addr=0x80, exmem_alu=0x44; flush_i[2]=1 next edge -> ID/EX bubble, exmem_wb_reg_wr=0 one cycle later.
- stall_i[3:2]=11 for 2 cycles with an ADDI held -> exmem_* unchanged. Stall plus flush on index 2 -> bubble.
- Assert rst mid-stream (asynchronously, between edges) -> all exmem_* read 0 immediately; br_jmp_en=0.
